count_adjust_date: RTL and testbench

- Day-of-month and month counter for the century clock.
- Sits directly upstream of the year counter. Advances on the day carry from the hour stage.
- Produces carry_mon on the Dec 31 -> Jan 1 rollover; the year counter consumes it.
- Takes the current year back from the year counter for leap-year handling. Supports manual adjust of day or month.

---
 rtl/clock_date_pkg.sv | 38 +++
 rtl/leap_year_detect.sv | 26 ++
 rtl/count_adjust_date.sv | 88 ++++++++
 tb/tb_count_adjust_date.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clock_date_pkg.sv
// Shared widths, month constants and the days-in-month helper for the century clock date path.
package clock_date_pkg;

  localparam int unsigned DAY_W  = 5;
  localparam int unsigned MON_W  = 4;
  localparam int unsigned YEAR_W = 14;

  localparam logic [MON_W-1:0] JAN = MON_W'(1);
  localparam logic [MON_W-1:0] FEB = MON_W'(2);
  localparam logic [MON_W-1:0] MAR = MON_W'(3);
  localparam logic [MON_W-1:0] APR = MON_W'(4);
  localparam logic [MON_W-1:0] MAY = MON_W'(5);
  localparam logic [MON_W-1:0] JUN = MON_W'(6);
  localparam logic [MON_W-1:0] JUL = MON_W'(7);
  localparam logic [MON_W-1:0] AUG = MON_W'(8);
  localparam logic [MON_W-1:0] SEP = MON_W'(9);
  localparam logic [MON_W-1:0] OCT = MON_W'(10);
  localparam logic [MON_W-1:0] NOV = MON_W'(11);
  localparam logic [MON_W-1:0] DEC = MON_W'(12);

  typedef enum logic {
    ADJ_DAY = 1'b0,
    ADJ_MON = 1'b1
  } adj_sel_e;

  // Illegal month codes fall into the 31-day bucket; the clamp keeps day legal anyway.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0] m,
                                                     input logic leap);
    logic [DAY_W-1:0] dim;
    case (m)
      FEB:               dim = leap ? DAY_W'(29) : DAY_W'(28);
      APR, JUN, SEP, NOV: dim = DAY_W'(30);
      default:           dim = DAY_W'(31);
    endcase
    return dim;
  endfunction

endpackage

// File: rtl/leap_year_detect.sv
// Combinational leap-year flag. Define GREGORIAN_CENTURY_RULE_EN for the full
// Gregorian rule; otherwise every multiple of 4 is leap (valid 1901..2099).
module leap_year_detect
  import clock_date_pkg::*;
(
  input  logic [YEAR_W-1:0] year,
  output logic              leap
);

`ifdef GREGORIAN_CENTURY_RULE_EN
  logic div4, div100, div400;

  always_comb begin
    div4   = (year[1:0] == 2'b00);
    div100 = ((year % YEAR_W'(100)) == '0);
    div400 = ((year % YEAR_W'(400)) == '0);
    leap   = div4 && (!div100 || div400);
  end
`else
  logic unused_year_hi;

  assign unused_year_hi = ^year[YEAR_W-1:2];
  assign leap           = (year[1:0] == 2'b00);
`endif

endmodule

// File: rtl/count_adjust_date.sv
// Day-of-month / month counter with manual adjust, leap handling and the year carry.
// Century leap rule selected by GREGORIAN_CENTURY_RULE_EN (see leap_year_detect).
module count_adjust_date
  import clock_date_pkg::*;
#(
  parameter int unsigned RESET_DAY   = 1,
  parameter int unsigned RESET_MONTH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              carry_day,
  input  logic [YEAR_W-1:0] year,
  input  logic              adj_en,
  input  logic              adj_sel,
  input  logic              adj_up,
  input  logic              adj_down,
  output logic [DAY_W-1:0]  day,
  output logic [MON_W-1:0]  month,
  output logic              carry_mon
);

  logic             leap;
  logic [DAY_W-1:0] dim_cur;
  logic [MON_W-1:0] month_step;
  logic [DAY_W-1:0] dim_step;
  logic             adj_step;
  logic [DAY_W-1:0] day_d;
  logic [MON_W-1:0] month_d;

  leap_year_detect u_leap (
    .year (year),
    .leap (leap)
  );

  // Candidate month for an adjust step, and its length for the same-edge day clamp.
  always_comb begin
    month_step = month;
    if (adj_up) begin
      month_step = (month == DEC) ? JAN : month + MON_W'(1);
    end else begin
      month_step = (month == JAN) ? DEC : month - MON_W'(1);
    end
    dim_cur  = days_in_month(month, leap);
    dim_step = days_in_month(month_step, leap);
    adj_step = adj_en && (adj_up ^ adj_down);
  end

  // Priority: adjust > carry_day count > clamp.
  always_comb begin
    day_d   = day;
    month_d = month;
    if (adj_step) begin
      if (adj_sel_e'(adj_sel) == ADJ_DAY) begin
        if (adj_up) begin
          day_d = (day == dim_cur) ? DAY_W'(1) : day + DAY_W'(1);
        end else begin
          day_d = (day == DAY_W'(1)) ? dim_cur : day - DAY_W'(1);
        end
      end else begin
        month_d = month_step;
        day_d   = (day > dim_step) ? dim_step : day;
      end
    end else if (!adj_en && carry_day) begin
      if (day < dim_cur) begin
        day_d = day + DAY_W'(1);
      end else begin
        day_d   = DAY_W'(1);
        month_d = (month == DEC) ? JAN : month + MON_W'(1);
      end
    end else if (day > dim_cur) begin
      day_d = dim_cur;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day   <= DAY_W'(RESET_DAY);
      month <= MON_W'(RESET_MONTH);
    end else begin
      day   <= day_d;
      month <= month_d;
    end
  end

  // Same-cycle carry so the year counter steps on the edge the date wraps to 01-01.
  assign carry_mon = carry_day && !adj_en && (month == DEC) && (day == DAY_W'(31)) && !rst;

endmodule

// File: tb/tb_count_adjust_date.sv
// Self-checking bench for count_adjust_date: calendar reference model plus directed literal checks.
module tb_count_adjust_date;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        carry_day = 1'b0;
  logic [13:0] year = 14'd2023;
  logic        adj_en = 1'b0;
  logic        adj_sel = 1'b0;
  logic        adj_up = 1'b0;
  logic        adj_down = 1'b0;
  logic [4:0]  day;
  logic [3:0]  month;
  logic        carry_mon;

  int checks = 0;
  int errors = 0;
  int m_day;
  int m_month;

  always #5 clk = ~clk;

  count_adjust_date #(
    .RESET_DAY   (1),
    .RESET_MONTH (1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .carry_day (carry_day),
    .year      (year),
    .adj_en    (adj_en),
    .adj_sel   (adj_sel),
    .adj_up    (adj_up),
    .adj_down  (adj_down),
    .day       (day),
    .month     (month),
    .carry_mon (carry_mon)
  );

  function automatic bit is_leap(int y);
`ifdef GREGORIAN_CENTURY_RULE_EN
    return (y % 4 == 0) && ((y % 100 != 0) || (y % 400 == 0));
`else
    return (y % 4 == 0);
`endif
  endfunction

  function automatic int mdim(int m, int y);
    case (m)
      2:           return is_leap(y) ? 29 : 28;
      4, 6, 9, 11: return 30;
      default:     return 31;
    endcase
  endfunction

  function automatic bit model_carry();
    return carry_day && !adj_en && !rst && (m_month == 12) && (m_day == 31);
  endfunction

  // Calendar reference: what the date must become on each edge.
  always @(posedge clk or posedge rst) begin
    int d, m, dl, nm;
    if (rst) begin
      m_day   <= 1;
      m_month <= 1;
    end else begin
      d  = m_day;
      m  = m_month;
      dl = mdim(m, int'(year));
      if (adj_en && (adj_up != adj_down)) begin
        if (!adj_sel) begin
          if (adj_up) d = (d == dl) ? 1 : d + 1;
          else        d = (d == 1) ? dl : d - 1;
        end else begin
          if (adj_up) nm = (m == 12) ? 1 : m + 1;
          else        nm = (m == 1) ? 12 : m - 1;
          m = nm;
          if (d > mdim(m, int'(year))) d = mdim(m, int'(year));
        end
      end else if (!adj_en && carry_day) begin
        if (d < dl) d = d + 1;
        else begin
          d = 1;
          m = (m == 12) ? 1 : m + 1;
        end
      end else if (d > dl) begin
        d = dl;
      end
      m_day   <= d;
      m_month <= m;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // Continuous comparison against the model on every falling edge.
  always @(negedge clk) begin
    chk("model_day", 32'(day), 32'(m_day));
    chk("model_month", 32'(month), 32'(m_month));
    chk("model_carry_mon", 32'(carry_mon), 32'(model_carry()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    carry_day = 1'b0;
    adj_en    = 1'b0;
    adj_up    = 1'b0;
    adj_down  = 1'b0;
  endtask

  // Walk the date to (d, m) through adjust mode, navigating on the model state.
  task automatic set_date(input int d, input int m);
    int n;
    carry_day = 1'b0;
    adj_en    = 1'b1;
    adj_up    = 1'b1;
    adj_down  = 1'b0;
    adj_sel   = 1'b1;
    n = 0;
    while (m_month != m && n < 13) begin
      tick();
      n++;
    end
    adj_sel = 1'b0;
    n = 0;
    while (m_day != d && n < 32) begin
      tick();
      n++;
    end
    idle();
    chk("set_date_day", 32'(m_day), 32'(d));
    chk("set_date_month", 32'(m_month), 32'(m));
  endtask

  task automatic lit(input string tag, input int d, input int m);
    #2;
    chk({tag, "_day"}, 32'(day), 32'(d));
    chk({tag, "_month"}, 32'(month), 32'(m));
  endtask

  initial begin
    #1 rst = 1'b1;
    tick();
    tick();
    lit("reset_values", 1, 1);
    rst = 1'b0;
    tick();

    // Async reset mid-count.
    year = 14'd2023;
    set_date(15, 7);
    carry_day = 1'b1;
    #1 rst = 1'b1;
    #1;
    chk("async_reset_day", 32'(day), 32'd1);
    chk("async_reset_month", 32'(month), 32'd7 - 32'd6);
    chk("async_reset_carry_mon", 32'(carry_mon), 32'd0);
    tick();
    rst = 1'b0;
    idle();
    tick();

    // Dec 31 rollover with same-cycle carry.
    set_date(31, 12);
    carry_day = 1'b1;
    #1;
    chk("rollover_carry_mon", 32'(carry_mon), 32'd1);
    tick();
    idle();
    lit("rollover", 1, 1);

    // Leap and non-leap February.
    year = 14'd2024;
    set_date(28, 2);
    carry_day = 1'b1;
    tick();
    lit("leap_feb_28", 29, 2);
    tick();
    idle();
    lit("leap_feb_29", 1, 3);
    year = 14'd2023;
    set_date(28, 2);
    carry_day = 1'b1;
    tick();
    idle();
    lit("nonleap_feb_28", 1, 3);

    // Century years.
    year = 14'd2100;
    set_date(28, 2);
    carry_day = 1'b1;
    tick();
    idle();
`ifdef GREGORIAN_CENTURY_RULE_EN
    lit("century_2100", 1, 3);
`else
    lit("century_2100", 29, 2);
`endif
    year = 14'd2000;
    set_date(28, 2);
    carry_day = 1'b1;
    tick();
    idle();
    lit("century_2000", 29, 2);

    // Month adjust with same-edge day clamp.
    year = 14'd2023;
    set_date(31, 1);
    adj_en = 1'b1; adj_sel = 1'b1; adj_up = 1'b1;
    tick();
    idle();
    lit("mon_adj_clamp_2023", 28, 2);
    year = 14'd2024;
    set_date(31, 1);
    adj_en = 1'b1; adj_sel = 1'b1; adj_up = 1'b1;
    tick();
    idle();
    lit("mon_adj_clamp_2024", 29, 2);
    set_date(10, 1);
    adj_en = 1'b1; adj_sel = 1'b1; adj_down = 1'b1;
    tick();
    idle();
    lit("mon_adj_down_wrap", 10, 12);

    // Year change pushes Feb 29 into a non-leap year: one-edge clamp.
    year = 14'd2024;
    set_date(29, 2);
    year = 14'd2025;
    lit("year_clamp_before", 29, 2);
    tick();
    lit("year_clamp_after", 28, 2);

    // Hold with both adjust strobes, and carry_day ignored in adjust mode.
    adj_en = 1'b1; adj_sel = 1'b0; adj_up = 1'b1; adj_down = 1'b1;
    tick();
    lit("adj_both_hold", 28, 2);
    year = 14'd2023;
    set_date(31, 12);
    adj_en = 1'b1; carry_day = 1'b1;
    #1;
    chk("adj_carry_mon_blocked", 32'(carry_mon), 32'd0);
    tick();
    idle();
    lit("adj_carry_ignored", 31, 12);
    adj_en = 1'b1; adj_sel = 1'b0; adj_up = 1'b1;
    tick();
    idle();
    lit("day_adj_up_wrap", 1, 12);
    adj_en = 1'b1; adj_sel = 1'b0; adj_down = 1'b1;
    tick();
    idle();
    lit("day_adj_down_wrap", 31, 12);

    // Randomized phase against the model.
    for (int i = 0; i < 3000; i++) begin
      carry_day = 1'($urandom_range(0, 1));
      adj_en    = ($urandom_range(0, 3) == 0);
      adj_sel   = 1'($urandom_range(0, 1));
      adj_up    = 1'($urandom_range(0, 1));
      adj_down  = 1'($urandom_range(0, 1));
      rst       = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 39) == 0) begin
        case ($urandom_range(0, 5))
          0:       year = 14'd1900;
          1:       year = 14'd2000;
          2:       year = 14'd2023;
          3:       year = 14'd2024;
          4:       year = 14'd2100;
          default: year = 14'($urandom_range(1, 9999));
        endcase
      end
      tick();
    end
    rst = 1'b0;
    idle();
    tick();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
